// File: rtl/lzd_normalizer.sv
// Leading-one detector and left normaliser for URNG samples: two-stage
// valid/ready pipeline producing exponent/fraction plus a zero-sample counter.
module lzd_normalizer #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [DATA_W-2:0] out_frac,
  output logic              out_zero,
  output logic [CNT_W-1:0]  zero_cnt,
  input  logic              zero_cnt_clr
);

  // MSB-first priority encode: ascending scan, so the highest set bit wins.
  function automatic logic [EXP_W-1:0] lead_one(input logic [DATA_W-1:0] d);
    lead_one = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) lead_one = i[EXP_W-1:0];
    end
  endfunction

  // Shift the leading one to the MSB and drop it (the implicit 1 of 1.frac).
  function automatic logic [DATA_W-2:0] normalize(input logic [DATA_W-1:0] d,
                                                  input logic [EXP_W-1:0]  idx);
    logic [EXP_W-1:0]  sh;
    logic [DATA_W-1:0] w;
    sh = EXP_W'(DATA_W - 1) - idx;
    w  = d << sh;
    normalize = w[DATA_W-2:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [EXP_W-1:0]  idx_p1;
  logic              nz_p1;

  logic              vld_p2;
  logic [EXP_W-1:0]  exp_p2;
  logic [DATA_W-2:0] frac_p2;
  logic              zero_p2;
  logic [CNT_W-1:0]  cnt_q;

  logic s1_adv;
  logic s2_adv;
  logic in_fire;
  logic out_fire;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;
  assign out_fire = vld_p2 && out_ready;

  // ---- stage 1: capture sample, priority encode ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_p1 <= in_data;
      idx_p1  <= lead_one(in_data);
      nz_p1   <= |in_data;
    end
  end

  // ---- stage 2: normalise into the output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      exp_p2  <= '0;
      frac_p2 <= '0;
      zero_p2 <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        exp_p2  <= idx_p1;
        frac_p2 <= normalize(data_p1, idx_p1);
        zero_p2 <= ~nz_p1;
      end
    end
  end

  // ---- output side: zero-sample counter, clear beats increment ----
  always_ff @(posedge clk) begin
    if (rst || zero_cnt_clr) begin
      cnt_q <= '0;
    end else if (out_fire && zero_p2) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign out_valid = vld_p2;
  assign out_exp   = exp_p2;
  assign out_frac  = frac_p2;
  assign out_zero  = zero_p2;
  assign zero_cnt  = cnt_q;

endmodule

// File: tb/tb_lzd_normalizer.sv
// Directed self-checking bench for lzd_normalizer: latency, encoding,
// zero counter saturation/clear, back-pressure and mid-stream reset.
module tb_lzd_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_exp;
  logic [30:0] out_frac;
  logic        out_zero;
  logic [15:0] zero_cnt;
  logic        zero_cnt_clr;

  int total = 0;
  int bad   = 0;

  lzd_normalizer #(.DATA_W(32), .EXP_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_frac(out_frac), .out_zero(out_zero),
    .zero_cnt(zero_cnt), .zero_cnt_clr(zero_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; zero_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_exp !== 5'd0 || out_frac !== 31'd0 || out_zero !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got exp=%0d frac=%h zero=%b want 0 0 0", out_exp, out_frac, out_zero);
    end
    total++; if (zero_cnt !== 16'd0) begin bad++; $display("FAIL reset_zero_cnt: got %h want 0000", zero_cnt); end
  endtask

  // One sample through an idle pipeline with out_ready high.
  task automatic push_single(input string name, input logic [31:0] d, input logic [4:0] e_exp,
                             input logic [30:0] e_frac, input logic e_zero, input logic clr_on_deliver);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_latency: got out_valid=%b want 0", name, out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
    total++; if (out_exp !== e_exp) begin bad++; $display("FAIL %s_exp: got %0d want %0d", name, out_exp, e_exp); end
    total++; if (out_frac !== e_frac) begin bad++; $display("FAIL %s_frac: got %h want %h", name, out_frac, e_frac); end
    total++; if (out_zero !== e_zero) begin bad++; $display("FAIL %s_zero: got %b want %b", name, out_zero, e_zero); end
    zero_cnt_clr = clr_on_deliver;
    @(negedge clk);
    zero_cnt_clr = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain: got out_valid=%b want 0", name, out_valid); end
  endtask

  task automatic test_encode();
    push_single("msb",      32'h8000_0000, 5'd31, 31'h0000_0000, 1'b0, 1'b0);
    push_single("lsb",      32'h0000_0001, 5'd0,  31'h0000_0000, 1'b0, 1'b0);
    push_single("mid",      32'h0001_2345, 5'd16, 31'h11A2_8000, 1'b0, 1'b0);
    push_single("ones",     32'h7FFF_FFFF, 5'd30, 31'h7FFF_FFFE, 1'b0, 1'b0);
    push_single("pair",     32'h00C0_0000, 5'd23, 31'h4000_0000, 1'b0, 1'b0);
    total++; if (zero_cnt !== 16'd0) begin bad++; $display("FAIL nonzero_cnt: got %h want 0000", zero_cnt); end
  endtask

  task automatic test_zero();
    push_single("zero", 32'h0000_0000, 5'd0, 31'd0, 1'b1, 1'b0);
    total++; if (zero_cnt !== 16'd1) begin bad++; $display("FAIL zero_cnt_inc: got %h want 0001", zero_cnt); end
    @(negedge clk) zero_cnt_clr = 1'b1;
    @(negedge clk) zero_cnt_clr = 1'b0;
    total++; if (zero_cnt !== 16'd0) begin bad++; $display("FAIL zero_cnt_clr: got %h want 0000", zero_cnt); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (zero_cnt !== 16'hFFFF) begin bad++; $display("FAIL zero_cnt_full: got %h want FFFF", zero_cnt); end
    push_single("zero_sat", 32'h0, 5'd0, 31'd0, 1'b1, 1'b0);
    total++; if (zero_cnt !== 16'hFFFF) begin bad++; $display("FAIL zero_cnt_sat: got %h want FFFF", zero_cnt); end
    push_single("zero_clr", 32'h0, 5'd0, 31'd0, 1'b1, 1'b1);
    total++; if (zero_cnt !== 16'h0000) begin bad++; $display("FAIL zero_cnt_clr_prio: got %h want 0000", zero_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec  [4] = '{32'h4000_0000, 32'h0000_0003, 32'h00F0_0000, 32'h0000_0100};
    logic [4:0]  eexp [4] = '{5'd30, 5'd1, 5'd23, 5'd8};
    logic [30:0] efrac[4] = '{31'h0, 31'h4000_0000, 31'h7000_0000, 31'h0};
    int k = 0, j = 0, first = -1, last = -1;
    logic acc_in, acc_out;
    @(negedge clk) out_ready = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 8) out_ready = 1'b1;
      in_valid = (k < 4);
      in_data  = (k < 4) ? vec[k] : 32'h0;
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (out_valid && !out_ready) begin
        total++;
        if (out_exp !== 5'd30 || out_frac !== 31'h0 || out_zero !== 1'b0) begin
          bad++; $display("FAIL b2b_hold: got exp=%0d frac=%h want 30 0", out_exp, out_frac);
        end
      end
      if (cyc == 6) begin
        total++; if (k !== 2) begin bad++; $display("FAIL b2b_capacity: got accepted=%0d want 2", k); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
      end
      if (acc_out) begin
        if (j < 4) begin
          total++;
          if (out_exp !== eexp[j] || out_frac !== efrac[j]) begin
            bad++; $display("FAIL b2b_out%0d: got exp=%0d frac=%h want exp=%0d frac=%h", j, out_exp, out_frac, eexp[j], efrac[j]);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        j++;
      end
      @(posedge clk);
      if (acc_in) k++;
    end
    total++; if (j !== 4) begin bad++; $display("FAIL b2b_count: got %0d deliveries want 4", j); end
    total++; if (last - first !== 3) begin bad++; $display("FAIL b2b_consecutive: got span %0d want 3", last - first); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_flush();
    push_single("pre_rst_zero", 32'h0, 5'd0, 31'd0, 1'b1, 1'b0);
    total++; if (zero_cnt !== 16'd1) begin bad++; $display("FAIL pre_rst_cnt: got %h want 0001", zero_cnt); end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
    @(negedge clk) in_data = 32'h0;
    @(negedge clk) in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_flush_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_flush_ready: got %b want 1", in_ready); end
    total++; if (zero_cnt !== 16'd0) begin bad++; $display("FAIL rst_flush_cnt: got %h want 0000", zero_cnt); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ghost%0d: got out_valid=%b want 0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_zero();
    test_saturation();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
